quadrature_gen: RTL and testbench
=================================

Name: quadrature_gen

Overview:
- Quadrature A/B waveform generator: takes a commanded number of quarter-phase transitions plus a direction, and emits a Gray-coded A/B pair at a programmable rate.
- Used as closed-loop stimulus for the rotary-encoder counter path and as an emulated encoder source in the RGB mixer.
- Accepts commands over a valid/ready handshake and tracks a signed running position.

Parameters:
- STEP_WIDTH, 16, width of cmd_steps (transitions per command).
- DIV_WIDTH, 16, width of cmd_period (clk cycles between transitions).
- POS_WIDTH, 16, width of the position tally (two's complement).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd_dir  in  1  1 = forward, 0 = reverse
- cmd_steps  in  STEP_WIDTH  number of quarter-phase transitions, unsigned
- cmd_period  in  DIV_WIDTH  cycles between transitions; 0 is treated as 1
- abort  in  1  stop the active command
- a  out  1  quadrature channel A, registered
- b  out  1  quadrature channel B, registered
- busy  out  1  command in progress (RUN or DONE state)
- done  out  1  one-cycle completion pulse
- position  out  POS_WIDTH  signed count of transitions emitted

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk.
  - While reset is held: a=0, b=0, phase=0, position=0, busy=0, done=0, cmd_ready=0, state=IDLE.
  - Reset overrides everything, including mid-run: the run is discarded, outputs return to reset values, and no done pulse is issued.
- Phase encoding (AB): phase0=00, phase1=10, phase2=11, phase3=01.
  - Forward: phase+1 mod 4, i.e. 00→10→11→01→00 (A leads B).
  - Reverse: phase−1 mod 4, i.e. 00→01→11→10→00.
  - Exactly one of a/b toggles per transition. a and b are driven directly from phase flops, so there are no glitches.
  - Phase persists across commands and is cleared only by reset.
- FSM states: IDLE, RUN, DONE.
  - IDLE: cmd_ready=1, busy=0.
    - On cmd_valid&&cmd_ready at edge k: latch dir, remaining=cmd_steps, P=max(cmd_period,1), timer=P; go to RUN.
    - abort is ignored in IDLE.
  - RUN: cmd_ready=0, busy=1. Each cycle, timer decrements.
    - If remaining==0: go to DONE at the next edge. For a zero-step command this means done is high between edge k+1 and edge k+2, with no a/b change.
    - Otherwise, transitions land at edges k+P, k+2P, …, k+N·P. At each one: phase advances, position ±1, remaining−1, timer reloads to P.
    - At the edge of the final transition (remaining 1→0), state goes to DONE. The last a/b change and done are visible in the same cycle.
  - DONE: done=1 and busy=1 for exactly one cycle, then IDLE (cmd_ready=1 on the following cycle).
- Abort: abort sampled high at an edge while in RUN means:
  - no transition at that edge, even if one is due (abort has priority);
  - go to DONE; a/b/phase/position hold.
- Latching rules:
  - cmd_period, cmd_dir and cmd_steps are sampled only on acceptance; later changes during RUN are ignored.
  - cmd_valid while not ready is not accepted and not queued. The source must hold cmd_valid until ready.
- Position arithmetic: modulo 2^POS_WIDTH.
  - +1 per forward transition, −1 per reverse.
  - Wraps 0x7FFF→0x8000 and 0x0000→0xFFFF without saturation.
- Throughput: back-to-back commands have a minimum gap of 1 IDLE cycle after DONE.

Test Plan:
- Reset, then accept fwd, steps=4, period=3 at edge k → AB=10@k+3, 11@k+6, 01@k+9, 00@k+12. done=1 only in the cycle after edge k+12. position=4. cmd_ready=1 after edge k+13.
- Then accept rev, steps=3, period=0 (treated as 1) → AB=01, 11, 10 on consecutive edges k+1..k+3. position=1. busy drops after DONE.
- steps=0, period=5 → no a/b change; done pulses between edge k+1 and k+2; position unchanged.
- fwd, steps=10, period=2; assert abort at edge k+4 (coinciding with the second transition's due edge) → only 1 transition (AB=10). done next cycle. position=+1. phase held at 10.
- cmd_valid held high during RUN with different fields → no second accept until IDLE; the first command completes with its latched values. Changing cmd_period mid-run does not alter spacing.
- Set position to 0x7FFF via 32767 fwd steps (period=1), then 1 more fwd → position=0x8000. Assert reset mid-run → a=b=0, position=0, done never pulses.

Source files
------------

// File: rtl/quadrature_gen.sv
// quadrature_gen: quadrature A/B generator driven by step/direction commands.
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   cmd_valid/ready    command handshake (accepted only in IDLE)
//   cmd_dir            1 = forward (A leads B), 0 = reverse
//   cmd_steps          number of quarter-phase transitions
//   cmd_period         clk cycles between transitions (0 behaves as 1)
//   abort              ends the running command without a further transition
//   a, b               Gray-coded quadrature outputs, straight from flops
//   busy, done         command in progress; one-cycle completion pulse
//   position           signed running tally of transitions, wraps modulo 2^POS_WIDTH
module quadrature_gen #(
    parameter int STEP_WIDTH = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int POS_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_dir,
    input  logic [STEP_WIDTH-1:0] cmd_steps,
    input  logic [DIV_WIDTH-1:0]  cmd_period,
    input  logic                  abort,
    output logic                  a,
    output logic                  b,
    output logic                  busy,
    output logic                  done,
    output logic [POS_WIDTH-1:0]  position
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state, state_n;
    logic                  dir, dir_n, a_n, b_n, step;
    logic [STEP_WIDTH-1:0] remaining, remaining_n;
    logic [DIV_WIDTH-1:0]  timer, timer_n, period, period_n;
    logic [POS_WIDTH-1:0]  position_n;

    assign cmd_ready = (state == IDLE) && !reset;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_comb begin
        state_n     = state;
        dir_n       = dir;
        remaining_n = remaining;
        timer_n     = timer;
        period_n    = period;
        step        = 1'b0;
        case (state)
            IDLE: if (cmd_valid) begin
                state_n     = RUN;
                dir_n       = cmd_dir;
                remaining_n = cmd_steps;
                period_n    = (cmd_period == '0) ? DIV_WIDTH'(1) : cmd_period;
                timer_n     = period_n;
            end
            RUN: if (abort || remaining == '0) begin
                state_n = DONE;
            end else if (timer <= DIV_WIDTH'(1)) begin
                step        = 1'b1;
                remaining_n = remaining - STEP_WIDTH'(1);
                timer_n     = period;
                state_n     = (remaining == STEP_WIDTH'(1)) ? DONE : RUN;
            end else begin
                timer_n = timer - DIV_WIDTH'(1);
            end
            default: state_n = IDLE;
        endcase
        // Gray stepping on the A/B pair itself: forward 00->10->11->01, reverse the opposite way.
        a_n        = step ? (dir ? ~b : b) : a;
        b_n        = step ? (dir ? a : ~a) : b;
        position_n = step ? (dir ? position + POS_WIDTH'(1) : position - POS_WIDTH'(1)) : position;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dir       <= 1'b0;
            remaining <= '0;
            timer     <= '0;
            period    <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            position  <= '0;
        end else begin
            state     <= state_n;
            dir       <= dir_n;
            remaining <= remaining_n;
            timer     <= timer_n;
            period    <= period_n;
            a         <= a_n;
            b         <= b_n;
            position  <= position_n;
        end
    end
endmodule

// File: tb/tb_quadrature_gen.sv
// tb_quadrature_gen: directed vector bench for quadrature_gen.
module tb_quadrature_gen;
    logic        clk = 1'b0;
    logic        reset, cmd_valid, cmd_ready, cmd_dir, abort, a, b, busy, done;
    logic [15:0] cmd_steps, cmd_period, position;

    int tests = 0;
    int fails = 0;
    int double_toggles = 0;

    quadrature_gen dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
        .abort(abort), .a(a), .b(b), .busy(busy), .done(done), .position(position)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dir;
        int          steps;
        int          period;
        int          n;
        int          first;
        int          last;
        logic [1:0]  ab;
        logic [15:0] pos;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic d, input int s, input int p);
        int w;
        w = 0;
        while (!cmd_ready && w < 50) begin
            tick();
            w++;
        end
        if (!cmd_ready) chk("ready_wait", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_dir    = d;
        cmd_steps  = 16'(s);
        cmd_period = 16'(p);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n, output int first,
                             output int last, output int tog, output int rdy);
        logic [1:0] prev;
        prev  = {a, b};
        n     = 0;
        first = 0;
        last  = 0;
        tog   = 0;
        rdy   = 0;
        do begin
            tick();
            n++;
            if ({a, b} != prev) begin
                tog++;
                if (first == 0) first = n;
                last = n;
                if (({a, b} ^ prev) == 2'b11) double_toggles++;
                prev = {a, b};
            end
            if (cmd_ready) rdy++;
        end while (!done && n < limit);
        if (!done) chk("done_timeout", done, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_ab", {a, b}, 0);
        chk("rst_pos", position, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", cmd_ready, 0);
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int n, first, last, tog, rdy, dcount;
        vecs[0] = '{1'b1, 4, 3, 12, 3, 12, 2'b00, 16'h0004};
        vecs[1] = '{1'b0, 3, 0, 3, 1, 3, 2'b10, 16'h0001};
        vecs[2] = '{1'b1, 0, 5, 1, 0, 0, 2'b10, 16'h0001};
        vecs[3] = '{1'b1, 5, 1, 5, 1, 5, 2'b11, 16'h0006};
        vecs[4] = '{1'b0, 6, 2, 12, 2, 12, 2'b00, 16'h0000};
        vecs[5] = '{1'b0, 1, 4, 4, 4, 4, 2'b01, 16'hFFFF};
        cmd_valid  = 1'b0;
        cmd_dir    = 1'b0;
        cmd_steps  = '0;
        cmd_period = '0;
        abort      = 1'b0;
        do_reset();
        chk("idle_ready", cmd_ready, 1);

        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].dir, vecs[i].steps, vecs[i].period);
            wait_done(100, n, first, last, tog, rdy);
            chk($sformatf("v%0d_done_edge", i), n, vecs[i].n);
            chk($sformatf("v%0d_first", i), first, vecs[i].first);
            chk($sformatf("v%0d_last", i), last, vecs[i].last);
            chk($sformatf("v%0d_toggles", i), tog, vecs[i].steps);
            chk($sformatf("v%0d_ab", i), {a, b}, vecs[i].ab);
            chk($sformatf("v%0d_pos", i), position, vecs[i].pos);
            chk($sformatf("v%0d_busy_done", i), busy, 1);
            tick();
            chk($sformatf("v%0d_done_drop", i), done, 0);
            chk($sformatf("v%0d_busy_drop", i), busy, 0);
            chk($sformatf("v%0d_ready", i), cmd_ready, 1);
        end

        // Abort landing on the edge where the second transition is due.
        do_reset();
        issue(1'b1, 10, 2);
        repeat (3) tick();
        chk("abort_pre_ab", {a, b}, 2'b10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done", done, 1);
        chk("abort_ab", {a, b}, 2'b10);
        chk("abort_pos", position, 1);
        tick();
        chk("abort_idle", cmd_ready, 1);
        chk("abort_hold_ab", {a, b}, 2'b10);

        // cmd_valid held through a run with new fields: only latched values count.
        cmd_valid  = 1'b1;
        cmd_dir    = 1'b1;
        cmd_steps  = 16'd3;
        cmd_period = 16'd2;
        tick();
        cmd_dir    = 1'b0;
        cmd_steps  = 16'd7;
        cmd_period = 16'd1;
        wait_done(100, n, first, last, tog, rdy);
        chk("hold_done_edge", n, 6);
        chk("hold_first", first, 2);
        chk("hold_toggles", tog, 3);
        chk("hold_no_ready", rdy, 0);
        chk("hold_ab", {a, b}, 2'b00);
        chk("hold_pos", position, 4);
        tick();
        chk("hold_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        wait_done(100, n, first, last, tog, rdy);
        chk("second_done_edge", n, 7);
        chk("second_ab", {a, b}, 2'b10);
        chk("second_pos", position, 16'hFFFD);
        tick();

        // Drive position up to the signed wrap point, then cross it.
        do_reset();
        issue(1'b1, 32767, 1);
        wait_done(40000, n, first, last, tog, rdy);
        chk("max_done_edge", n, 32767);
        chk("max_pos", position, 16'h7FFF);
        chk("max_ab", {a, b}, 2'b01);
        tick();
        issue(1'b1, 1, 1);
        wait_done(100, n, first, last, tog, rdy);
        chk("wrap_pos", position, 16'h8000);
        chk("wrap_ab", {a, b}, 2'b00);
        tick();

        // Reset in the middle of a run discards it without a done pulse.
        issue(1'b1, 100, 1);
        repeat (5) tick();
        chk("midrun_busy", busy, 1);
        reset = 1'b1;
        dcount = 0;
        tick();
        chk("mid_rst_ab", {a, b}, 0);
        chk("mid_rst_pos", position, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cmd_ready, 0);
        reset = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (done) dcount++;
            tick();
        end
        chk("mid_rst_no_done", dcount, 0);
        chk("mid_rst_pos_after", position, 0);
        chk("mid_rst_ready_after", cmd_ready, 1);

        chk("single_bit_toggles", double_toggles, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
